// File: rtl/result_uart_tx.sv
// result_uart_tx: once the CPU halts, captures the 16-bit result and sends it
// to a host as a three-byte 8N1 UART packet: SYNC_BYTE, result[15:8], result[7:0].
// One packet per run. After the packet is sent, only reset re-arms the block.
module result_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 8,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        halt,
   input  logic [15:0] result,
   output logic        tx,
   output logic        busy,
   output logic        done
);

   // Bit-period counter runs 0 .. CLKS_PER_BIT-1.
   localparam int unsigned    CNT_W    = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]       state_q,    state_d;
   logic             halt_q;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [2:0]       bit_idx_q,  bit_idx_d;
   logic [1:0]       byte_idx_q, byte_idx_d;
   logic [7:0]       shift_q,    shift_d;
   logic [15:0]      shadow_q,   shadow_d;
   logic             tx_q,       tx_d;
   logic             busy_q,     busy_d;
   logic             done_q,     done_d;

   logic bit_end;
   logic capture;

   assign bit_end = (cnt_q == CNT_LAST);
   // halt_q resets to 0, so a halt that is already high at reset release
   // counts as a rising edge.
   assign capture = halt && !halt_q;

   // Next-state logic. The line level for each bit is computed here and
   // registered, so tx changes on the same edge that starts the bit.
   always_comb begin
      // NOTE: every _d signal gets a default first. A path that leaves one
      // unassigned would infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      shadow_d   = shadow_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = done_q;

      // The counter free-runs while a bit is on the line and wraps at each
      // bit boundary.
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end else begin
         cnt_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (capture) begin
               shadow_d   = result;
               shift_d    = SYNC_BYTE;
               byte_idx_d = 2'd0;
               state_d    = S_START;
               tx_d       = 1'b0;
               busy_d     = 1'b1;
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d   = S_DATA;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
               shift_d   = {1'b0, shift_q[7:1]};
            end
         end

         // LSB first. shift_q[0] always holds the next bit to send.
         S_DATA: begin
            if (bit_end) begin
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  tx_d      = shift_q[0];
                  shift_d   = {1'b0, shift_q[7:1]};
               end
            end
         end

         // After a stop bit, either go straight to the next frame's start
         // bit with no idle gap, or finish the packet.
         S_STOP: begin
            if (bit_end) begin
               if (byte_idx_q < 2'd2) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  shift_d    = (byte_idx_q == 2'd0) ? shadow_q[15:8] : shadow_q[7:0];
                  state_d    = S_START;
                  tx_d       = 1'b0;
               end else begin
                  state_d = S_DONE;
                  tx_d    = 1'b1;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end

         // Terminal state. Later halt edges are ignored until reset.
         S_DONE: begin
            tx_d = 1'b1;
         end

         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   // Edge-detect register for halt.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         halt_q <= 1'b0;
      end else begin
         halt_q <= halt;
      end
   end

   // State and datapath registers. The outputs come straight from flops.
   always_ff @(posedge clk or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // flop samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= 3'd0;
         byte_idx_q <= 2'd0;
         shift_q    <= 8'd0;
         shadow_q   <= 16'd0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         shadow_q   <= shadow_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx. Instance A uses CLKS_PER_BIT=4 and instance B uses
// the minimum divider of 2. Stimulus pushes the expected packet bytes to a
// queue. A line monitor pops them and checks each tx sample and each decoded byte.
module tb_result_uart_tx;

   localparam int CPB_A = 4;
   localparam int CPB_B = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        halt_a, halt_b;
   logic [15:0] result_a, result_b;
   logic        tx_a, busy_a, done_a;
   logic        tx_b, busy_b, done_b;

   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q[$];

   result_uart_tx #(.CLKS_PER_BIT(CPB_A), .SYNC_BYTE(8'hA5)) dut_a (
      .clk(clk), .reset(reset), .halt(halt_a), .result(result_a),
      .tx(tx_a), .busy(busy_a), .done(done_a)
   );

   result_uart_tx #(.CLKS_PER_BIT(CPB_B), .SYNC_BYTE(8'hA5)) dut_b (
      .clk(clk), .reset(reset), .halt(halt_b), .result(result_b),
      .tx(tx_b), .busy(busy_b), .done(done_b)
   );

   always #5 clk = ~clk;

   // Counts posedges. At the negedge following posedge n, cyc equals n.
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_packet(input logic [15:0] res);
      exp_q.push_back(8'hA5);
      exp_q.push_back(res[15:8]);
      exp_q.push_back(res[7:0]);
   endtask

   // Call this at the negedge that follows the capture edge. It consumes
   // exactly 30 bit periods and returns at the negedge of edge E + 30*C.
   task automatic rx_packet(input int sel);
      int         c;
      logic [7:0] exp_b;
      logic [7:0] got;
      logic [9:0] frame;
      logic       s;
      c = (sel == 0) ? CPB_A : CPB_B;
      for (int f = 0; f < 3; f++) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            exp_b = 8'h00;
         end else begin
            exp_b = exp_q.pop_front();
         end
         frame = {1'b1, exp_b, 1'b0};
         got   = 8'h00;
         for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < c; j++) begin
               s = (sel == 0) ? tx_a : tx_b;
               check($sformatf("d%0d_f%0d_bit%0d_s%0d", sel, f, b, j), {31'd0, s}, {31'd0, frame[b]});
               if (j == c / 2 && b >= 1 && b <= 8) got[b-1] = s;
               if (j == 0) check($sformatf("d%0d_busy_f%0d_b%0d", sel, f, b),
                                 {31'd0, (sel == 0) ? busy_a : busy_b}, 32'd1);
               @(negedge clk);
            end
         end
         check($sformatf("d%0d_rx_byte%0d", sel, f), {24'd0, got}, {24'd0, exp_b});
      end
   endtask

   task automatic check_end_a(input string tag);
      check({tag, "_done"}, {31'd0, done_a}, 32'd1);
      check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
      check({tag, "_tx"},   {31'd0, tx_a},   32'd1);
   endtask

   initial begin
      int base;
      int lows;
      int e_cyc;

      reset    = 1'b1;
      halt_a   = 1'b0;
      halt_b   = 1'b0;
      result_a = 16'h002A;
      result_b = 16'hFFFF;
      repeat (3) @(negedge clk);

      // Reset values.
      check("rst_tx_a",   {31'd0, tx_a},   32'd1);
      check("rst_busy_a", {31'd0, busy_a}, 32'd0);
      check("rst_done_a", {31'd0, done_a}, 32'd0);
      check("rst_tx_b",   {31'd0, tx_b},   32'd1);
      check("rst_busy_b", {31'd0, busy_b}, 32'd0);
      check("rst_done_b", {31'd0, done_b}, 32'd0);

      // Basic packet: halt rises so that relative edge 10 is the capture edge.
      reset = 1'b0;
      base  = cyc;
      while (cyc < base + 9) @(negedge clk);
      check("idle_tx_a", {31'd0, tx_a}, 32'd1);
      halt_a = 1'b1;
      push_packet(16'h002A);
      @(negedge clk);
      rx_packet(0);
      check_end_a("basic_end");

      // Sticky done: another halt edge must not start a packet.
      halt_a = 1'b0;
      repeat (3) @(negedge clk);
      halt_a = 1'b1;
      lows = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (tx_a !== 1'b1) lows++;
      end
      check("sticky_tx_lows", lows, 0);
      check_end_a("sticky");

      // Result changes after capture. Halt also falls and rises mid-packet.
      reset  = 1'b1;
      halt_a = 1'b0;
      @(negedge clk);
      check("rst2_done_a", {31'd0, done_a}, 32'd0);
      reset    = 1'b0;
      result_a = 16'hBEEF;
      @(negedge clk);
      halt_a = 1'b1;
      push_packet(16'hBEEF);
      @(negedge clk);
      fork
         rx_packet(0);
         begin
            @(negedge clk);
            result_a = 16'h1234;
            halt_a   = 1'b0;
            repeat (20) @(negedge clk);
            halt_a = 1'b1;
         end
      join
      check_end_a("beef_end");

      // Halt held high through reset: the packet starts at the first edge after release.
      reset    = 1'b1;
      result_a = 16'h5A3C;
      repeat (3) @(negedge clk);
      check("rst3_tx_a",   {31'd0, tx_a},   32'd1);
      check("rst3_busy_a", {31'd0, busy_a}, 32'd0);
      reset = 1'b0;
      push_packet(16'h5A3C);
      @(negedge clk);
      rx_packet(0);
      check_end_a("hold_end");

      // Reset mid-packet, during frame 1 data bit 3 (packet bit 14).
      reset    = 1'b1;
      result_a = 16'hC396;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      push_packet(16'hC396);
      @(negedge clk);
      repeat (14 * CPB_A + 2) @(negedge clk);
      check("pre_abort_d3", {31'd0, tx_a}, 32'd0);  // bit 3 of 0xC3
      #2 reset = 1'b1;
      #1;
      check("abort_tx",   {31'd0, tx_a},   32'd1);
      check("abort_busy", {31'd0, busy_a}, 32'd0);
      check("abort_done", {31'd0, done_a}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      push_packet(16'hC396);
      @(negedge clk);
      rx_packet(0);
      check_end_a("resend_end");

      // Minimum divider on instance B.
      halt_b = 1'b1;
      push_packet(16'hFFFF);
      @(negedge clk);
      e_cyc = cyc;
      rx_packet(1);
      for (int i = 0; i < 100; i++) begin
         if (done_b === 1'b1) break;
         @(negedge clk);
      end
      check("min_pkt_cycles", cyc - e_cyc, 60);
      check("min_busy_end", {31'd0, busy_b}, 32'd0);
      check("min_tx_end",   {31'd0, tx_b},   32'd1);

      check("sb_leftover", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Downstream reporting stage for `cpu_top`: watches the CPU's `halt` flag and, when the program finishes, captures the 16-bit `Result` bus and sends it off-chip as a three-byte UART (8N1) packet. The packet is a sync byte 0xA5, then `Result[15:8]`, then `Result[7:0]`. It sits beside `cpu_top` at the top level. It replaces testbench-only `$display` reporting with a synthesizable path to a host.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: clock cycles per UART bit. Legal range is 2 to 65535. The counter width is derived from it.
- `SYNC_BYTE`, default 8'hA5: first byte of every packet.

Ports:
- `clk`  in  1  system clock, shared with `cpu_top`.
- `reset`  in  1  asynchronous, active-high reset. It clears all state immediately.
- `halt`  in  1  CPU halt flag. It is a level that stays high once the CPU halts.
- `result`  in  16  CPU `Result` bus. Only sampled at capture.
- `tx`  out  1  UART serial line. Idle high.
- `busy`  out  1  high while a packet is being transmitted.
- `done`  out  1  high after the packet has been fully sent. Sticky until reset.

## Operation
- Reset values: `tx`=1, `busy`=0, `done`=0, state=IDLE, `halt_q`=0, bit counter=0, byte index=0, shadow register=0.
- `halt_q` is a registered copy of `halt`. The capture condition is `halt && !halt_q` while in IDLE.
- Because `halt_q` resets to 0, a `halt` that is already high when reset deasserts counts as a rising edge and triggers capture.
- States: IDLE, START, DATA, STOP, DONE.
- **IDLE**: `tx`=1.
  - On the capture condition: latch `result` into a 16-bit shadow register.
  - Load shift register = `SYNC_BYTE` and set byte index = 0.
  - Go to START and drive `tx`=0 and `busy`=1 at that same edge.
- **START**: hold `tx`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index = 0.
- **DATA**: send 8 bits LSB first, each held for `CLKS_PER_BIT` cycles. After bit 7, go to STOP.
- **STOP**: hold `tx`=1 for `CLKS_PER_BIT` cycles. Then:
  - If byte index < 2: increment it and load the next byte (index 1 = shadow[15:8], index 2 = shadow[7:0]). Go straight to START with no idle gap.
  - Otherwise: go to DONE, set `done`=1 and `busy`=0.
- **DONE**: `tx`=1. The block is terminal; only reset leaves it. A further `halt` edge is ignored, so exactly one report is sent per run.
- `result` changes after capture are ignored; the shadow register is used.
- `halt` falling or re-rising during transmission is ignored.
- `tx`, `busy` and `done` are all driven directly from flops, with no combinational output path.

## Timing
- Capture edge E is the first posedge where `halt`=1 and `halt_q`=0. At E, `tx` falls and `busy` rises; `tx` is registered, so there is no added latency.
- Each bit occupies exactly `CLKS_PER_BIT` cycles. A frame is 10 bits, and there are 3 back-to-back frames.
- `tx` follows this schedule:
  - Bit k of the packet (k = 0 to 29) is on the line from E + k·`CLKS_PER_BIT` until E + (k+1)·`CLKS_PER_BIT`.
  - Frame f's start bit is k = 10f.
  - Its data bits d0–d7 are k = 10f+1 to 10f+8.
  - Its stop bit is k = 10f+9.
- `busy` falls and `done` rises at edge E + 30·`CLKS_PER_BIT`.
- Asynchronous reset mid-packet: `tx` returns to 1 and `busy`/`done` to 0 immediately, with no partial stop bit. After release, a still-high `halt` starts a new packet from the sync byte.
- `halt` asserted in the same cycle that reset releases is seen on the first clock edge after release.

## Test plan
- **Basic packet**: `CLKS_PER_BIT`=4, `result`=16'h002A, raise `halt` at edge 10.
  - Expect `tx`=0 from edge 10 to 14.
  - Expect LSB-first bits of A5, then 00, then 2A, each framed by a start and stop bit.
  - Expect `done`=1 and `busy`=0 at edge 130.
- **Result changes after capture**: `result`=16'hBEEF at capture, changed to 16'h1234 one cycle later.
  - Decoded bytes must be A5, BE, EF.
- **Sticky done**: after `done`, toggle `halt` low then high.
  - `tx` stays 1, no new start bit, `done` stays 1.
- **Halt high at reset release**: hold `halt`=1 throughout reset.
  - The packet starts at the first posedge after reset deasserts.
- **Reset mid-packet**: assert `reset` during frame 1, data bit 3.
  - `tx`=1, `busy`=0, `done`=0 immediately, before the next clock edge.
  - After release with `halt`=1, a full A5-first packet is resent.
- **Minimum divider**: `CLKS_PER_BIT`=2, `result`=16'hFFFF.
  - Expect 60-cycle packet duration.
  - Stop bits are exactly 2 cycles high between frames.
